// File: rtl/fifo_pkg.sv
// fifo_pkg: items shared by the FIFO drain arbiter and its round-robin picker.
//   state_t : arbiter FSM states (IDLE -> POP -> WAIT -> SEND -> IDLE)
//   id_w()  : width of a channel index; never narrower than 1 bit, so that a
//             single-channel build still has a real (constant-zero) id port.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
//   req     : [N_REQ-1:0] request vector (1 = channel has data)
//   ptr     : [IDW-1:0]   channel with highest priority; must be < N_REQ
//   pick    : [IDW-1:0]   first requesting channel at or above ptr, wrapping
//                         modulo N_REQ (0 when nothing requests)
//   any_req : 1 when at least one request bit is set
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   pick,
  output logic             any_req
);

  // One extra bit so ptr + offset cannot overflow before the modulo wrap.
  localparam int SW = IDW + 1;

  logic [IDW-1:0]   cand [N_REQ];
  logic [N_REQ-1:0] hit;

  // cand[gi] is the channel sitting gi places after ptr; hit[gi] says whether
  // it requests. The wrap is a single conditional subtract because ptr < N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum       = {1'b0, ptr} + SW'(gi);
    assign cand[gi]  = (sum >= SW'(N_REQ)) ? IDW'(sum - SW'(N_REQ)) : sum[IDW-1:0];
    assign hit[gi]   = req[cand[gi]];
  end

  assign any_req = |req;

  // Scan from the far end so the smallest offset is written last and wins.
  always_comb begin
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pick = cand[i];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb: drains N_DTPS upstream FIFOs round-robin into one
// valid/ready stream, one word per IDLE->POP->WAIT->SEND pass.
//   clk, rst      : clock; asynchronous active-high reset
//   i_fifo_data   : channel k word at [k*FIFO_WIDTH +: FIFO_WIDTH], valid the
//                   cycle after o_pop[k]
//   i_fifo_empty  : per-channel empty flags (sampled only in IDLE)
//   o_pop         : per-channel pop strobe, one-hot during POP, else zero
//   o_data, o_id  : merged word and its source channel
//   o_valid       : high throughout SEND
//   i_ready       : consumer accepts the word (only meaningful in SEND)
//   o_count       : words delivered, saturating at all-ones
module fifo_drain_arb
  import fifo_pkg::*;
#(
  parameter int N_DTPS     = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_DTPS*FIFO_WIDTH-1:0] i_fifo_data,
  input  logic [N_DTPS-1:0]            i_fifo_empty,
  output logic [N_DTPS-1:0]            o_pop,
  output logic [FIFO_WIDTH-1:0]        o_data,
  output logic [id_w(N_DTPS)-1:0]      o_id,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [CNT_W-1:0]             o_count
);

  localparam int             IDW     = id_w(N_DTPS);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_DTPS - 1);

  state_t                  state_reg, state_next;
  logic [IDW-1:0]          grant_reg, grant_next;
  logic [IDW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]          id_reg, id_next;
  logic [FIFO_WIDTH-1:0]   data_reg, data_next;
  logic [CNT_W-1:0]        count_reg, count_next;

  logic [FIFO_WIDTH-1:0]   chan_data [N_DTPS];
  logic [N_DTPS-1:0]       req_vec;
  logic [IDW-1:0]          pick;
  logic                    any_req;

  assign req_vec = ~i_fifo_empty;

  for (genvar gi = 0; gi < N_DTPS; gi++) begin : g_chan
    assign chan_data[gi] = i_fifo_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    assign o_pop[gi]     = (state_reg == ST_POP) && (grant_reg == IDW'(gi));
  end

  rr_pick #(
    .N_REQ (N_DTPS),
    .IDW   (IDW)
  ) u_rr_pick (
    .req     (req_vec),
    .ptr     (rr_ptr_reg),
    .pick    (pick),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      data_reg   <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      id_reg     <= id_next;
      data_reg   <= data_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    id_next     = id_reg;
    data_next   = data_reg;
    count_next  = count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          grant_next = pick;
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Upstream data for the granted channel is valid in this cycle.
        data_next  = chan_data[grant_reg];
        id_next    = grant_reg;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (i_ready) begin
          rr_ptr_next = (grant_reg == LAST_ID) ? '0 : grant_reg + IDW'(1);
          if (count_reg != '1) begin
            count_next = count_reg + CNT_W'(1);
          end
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_valid = (state_reg == ST_SEND);
  assign o_data  = data_reg;
  assign o_id    = id_reg;
  assign o_count = count_reg;

endmodule

// File: doc/fifo_drain_arb.md
FIFO_DRAIN_ARB -- requirements
Module: fifo_drain_arb

Interface
REQ-001 Parameter N_DTPS, default 4, is the number of upstream FIFO channels (1..16).
REQ-002 Parameter FIFO_WIDTH, default 16, is the data width of each channel in bits.
REQ-003 Parameter CNT_W, default 16, is the width of the drained-word counter.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port i_fifo_data, input, N_DTPS*FIFO_WIDTH bits: channel k data occupies bits [k*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 Port i_fifo_empty, input, N_DTPS bits: the per-channel empty flag.
REQ-008 Port o_pop, output, N_DTPS bits: the per-channel pop strobe.
REQ-009 Port o_data, output, FIFO_WIDTH bits: the merged output word.
REQ-010 Port o_id, output, max(1,$clog2(N_DTPS)) bits: the source channel of o_data.
REQ-011 Port o_valid, output, 1 bit: o_data and o_id are valid.
REQ-012 Port i_ready, input, 1 bit: the consumer accepts the word this cycle.
REQ-013 Port o_count, output, CNT_W bits: the total number of words delivered, saturating.

Function
REQ-014 Upstream read contract: i_fifo_data for channel k is valid in the cycle after o_pop[k] is high.
REQ-015 The FSM has four states: IDLE, POP, WAIT and SEND.
REQ-016 In IDLE, if any i_fifo_empty bit is 0, the block registers grant as the first non-empty channel searching upward from rr_ptr with modulo-N_DTPS wrap, and moves to POP; otherwise it stays in IDLE.
REQ-017 In POP, o_pop[grant] is 1 for exactly one cycle, all other o_pop bits are 0, and the next state is WAIT.
REQ-018 In WAIT, the block captures i_fifo_data[grant] into o_data and grant into o_id, then moves to SEND.
REQ-019 In SEND, o_valid is 1 and o_data and o_id are held stable until i_ready is 1.
REQ-020 On the SEND handshake (o_valid & i_ready), rr_ptr becomes (grant+1) mod N_DTPS, o_count increments, and the next state is IDLE.
REQ-021 Latency: if IDLE sees a non-empty channel in cycle t, o_pop is high in t+1 and o_valid rises in t+3; peak throughput is one word per 4 cycles.
REQ-022 o_pop is one-hot or all-zero in every cycle; it is never high outside POP.
REQ-023 i_fifo_empty is sampled only in IDLE; changes in other states have no effect.
REQ-024 i_ready has no effect outside SEND; o_valid is never high outside SEND.
REQ-025 rr_ptr wraps from N_DTPS-1 to 0, including for non-power-of-two N_DTPS.
REQ-026 For N_DTPS=1, grant and rr_ptr are always 0 and o_id is a 1-bit constant 0.
REQ-027 o_count saturates at 2^CNT_W-1 and does not wrap.

Reset
REQ-028 While rst is high: the state is IDLE, rr_ptr=0, grant=0, o_pop=0, o_valid=0, o_data=0, o_id=0 and o_count=0.
REQ-029 Reset asserted in any state, including mid-SEND, drops the pending word without retrying it; the word popped upstream is lost.
REQ-030 The first IDLE evaluation occurs on the first rising clk edge after rst deasserts.

Structure
REQ-031 The state encoding typedef (IDLE, POP, WAIT, SEND) and the ID-width function belong in the shared package fifo_pkg.
REQ-032 The round-robin next-channel search is one sub-module, rr_pick: combinational, taking the request vector and the pointer and producing the grant index and an any-request flag.
REQ-033 fifo_drain_arb connects directly to the N_DTPS-channel FIFO bank: its data, empty and pop buses use identical slicing.

Verification
REQ-034 Apply reset, then hold all channels empty for 20 cycles -> o_pop=0, o_valid=0 and o_count=0 throughout.
REQ-035 Channel 2 only, holding 0xA5A5, with i_ready=1 -> o_pop=4'b0100 at t+1; at t+3, o_valid=1, o_data=0xA5A5 and o_id=2; o_count=1.
REQ-036 All 4 channels non-empty with words 0x1000+k, and i_ready=1 -> delivery order is ids 0,1,2,3,0, with exactly 4 cycles between handshakes.
REQ-037 i_ready=0 for 10 cycles during SEND -> o_valid, o_data and o_id stay stable, and no o_pop occurs; i_ready=1 -> a single handshake occurs.
REQ-038 Assert rst during WAIT -> on the next cycle all outputs are 0; after release, only the next non-empty channel is popped.
REQ-039 With CNT_W=3, deliver 9 words -> o_count reads 7 after the 7th, 8th and 9th words.
